ahb_qos_slave_arbiter: RTL

Per-slave AHB arbiter that shares one slave port among `N_MASTER` masters in the AHB_GEN bus matrix. It selects the next owner by 2-bit master priority, breaks ties round-robin, and promotes starved requesters through per-master aging counters. It holds ownership for the full length of fixed-length bursts and undefined-length INCR bursts. It drives the one-hot grant vector that steers the slave-side payload mux, plus the slave `hsel`.

---
 rtl/ahb_qos_slave_arbiter.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_qos_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_qos_slave_arbiter
//
// Shares one AHB slave port among N_MASTER masters. The next owner is chosen
// by priority, ties are broken round-robin, and requesters that have waited
// too long are promoted through per-master aging counters. Ownership is held
// for the whole of a fixed-length burst and for an undefined-length INCR
// burst while the owner keeps requesting.
//
// Ports
//   hclk          bus clock, all state changes on the rising edge
//   hreset        synchronous, active-high reset
//   hreq          per-master request (from each master's decoder)
//   hprior        per-master priority, master i at [i*PRIOR_W +: PRIOR_W]
//   htrans        HTRANS of the currently granted master
//   hburst        HBURST of the currently granted master
//   hwait         slave not ready (~hreadyout)
//   hgrant        registered grant, one-hot or all-zero
//   hmaster       index of the granted master, 0 when nobody is granted
//   hsel          slave select, combinational from the registered grant
//   burst_active  high while a fixed-length burst is in progress
// ---------------------------------------------------------------------------
module ahb_qos_slave_arbiter #(
    parameter int N_MASTER = 3,
    parameter int PRIOR_W  = 2,
    parameter int AGE_MAX  = 15,
    localparam int IDX_W   = $clog2(N_MASTER)
) (
    input  logic                        hclk,
    input  logic                        hreset,
    input  logic [N_MASTER-1:0]         hreq,
    input  logic [N_MASTER*PRIOR_W-1:0] hprior,
    input  logic [1:0]                  htrans,
    input  logic [2:0]                  hburst,
    input  logic                        hwait,
    output logic [N_MASTER-1:0]         hgrant,
    output logic [IDX_W-1:0]            hmaster,
    output logic                        hsel,
    output logic                        burst_active
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [7:0] AGE_LIM   = 8'(AGE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [N_MASTER-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]      master_q, master_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [3:0]            beats_q, beats_d;
    logic [7:0]            age_q [N_MASTER];
    logic [7:0]            age_d [N_MASTER];

    logic [PRIOR_W-1:0]    pri [N_MASTER];
    logic [N_MASTER-1:0]   urgent;
    logic [N_MASTER-1:0]   cand;
    logic [PRIOR_W-1:0]    max_pri;
    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    int                    scan_idx;

    logic                  tr_nonseq, tr_seq, tr_idle;
    logic                  owner_req;
    logic                  burst_fixed;
    logic [3:0]            burst_len_m1;
    logic                  arb_pt;
    logic                  burst_load;

    // ------------------------------------------------------------------
    // Transfer decode
    // ------------------------------------------------------------------
    assign tr_nonseq   = (htrans == TR_NONSEQ);
    assign tr_seq      = (htrans == TR_SEQ);
    assign tr_idle     = (htrans == TR_IDLE);
    // Owner's request without indexing: the grant is one-hot or zero.
    assign owner_req   = |(hreq & grant_q);
    // WRAP4/INCR4 and up are fixed-length bursts.
    assign burst_fixed = hburst[2] | hburst[1];

    always_comb begin
        burst_len_m1 = 4'd15;
        case (hburst[2:1])
            2'b01:   burst_len_m1 = 4'd3;
            2'b10:   burst_len_m1 = 4'd7;
            default: burst_len_m1 = 4'd15;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-master priority unpack, urgency and aging
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_master
            assign pri[gi]    = hprior[gi*PRIOR_W +: PRIOR_W];
            assign urgent[gi] = hreq[gi] && (age_q[gi] >= AGE_LIM);
            // Age is judged against the grant being loaded this edge, so a
            // master that has just won starts its next wait from zero.
            assign age_d[gi]  = (hreq[gi] && !grant_d[gi])
                              ? ((age_q[gi] >= AGE_LIM) ? AGE_LIM : age_q[gi] + 8'd1)
                              : 8'd0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Winner selection: urgent set first, then highest priority, then the
    // first match scanning upward from rr_q+1 with wrap.
    // ------------------------------------------------------------------
    always_comb begin
        cand      = (|urgent) ? urgent : hreq;
        max_pri   = '0;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (cand[i] && (pri[i] > max_pri)) begin
                max_pri = pri[i];
            end
        end
        for (int off = 1; off <= N_MASTER; off++) begin
            scan_idx = int'(rr_q) + off;
            if (scan_idx >= N_MASTER) begin
                scan_idx = scan_idx - N_MASTER;
            end
            if (!win_found && cand[scan_idx] && (pri[scan_idx] == max_pri)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration point and burst tracking
    // ------------------------------------------------------------------
    always_comb begin
        arb_pt     = 1'b0;
        burst_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_pt = 1'b1;
            end
            ST_OWN: begin
                if (!hwait) begin
                    // An INCR owner with IDLE and hreq still high keeps the
                    // bus: none of the three release conditions hold.
                    if (!owner_req
                        || (tr_nonseq && (hburst == HB_SINGLE))
                        || (tr_idle && (hburst != HB_INCR))) begin
                        arb_pt = 1'b1;
                    end else if (tr_nonseq && burst_fixed) begin
                        burst_load = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                if (!hwait) begin
                    // beats_q counts SEQ beats still to come, so the beat
                    // that takes it to zero is the last of the burst. A new
                    // NONSEQ or IDLE ends the burst early.
                    if (tr_nonseq || tr_idle) begin
                        arb_pt = 1'b1;
                    end else if (tr_seq && (beats_q <= 4'd1)) begin
                        arb_pt = 1'b1;
                    end
                end
            end
            default: begin
                arb_pt = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        master_d = master_q;
        rr_d     = rr_q;
        beats_d  = beats_q;
        if (arb_pt) begin
            beats_d = 4'd0;
            if (win_found) begin
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                master_d         = win_idx;
                rr_d             = win_idx;
                state_d          = ST_OWN;
            end else begin
                grant_d  = '0;
                master_d = '0;
                state_d  = ST_IDLE;
            end
        end else if (burst_load) begin
            state_d = ST_BURST;
            beats_d = burst_len_m1;
        end else if ((state_q == ST_BURST) && tr_seq && !hwait) begin
            beats_d = beats_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            master_q <= '0;
            // Start the pointer on the last master so master 0 wins the
            // first tie after reset.
            rr_q     <= IDX_W'(N_MASTER - 1);
            beats_q  <= 4'd0;
            for (int i = 0; i < N_MASTER; i++) begin
                age_q[i] <= 8'd0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            master_q <= master_d;
            rr_q     <= rr_d;
            beats_q  <= beats_d;
            for (int i = 0; i < N_MASTER; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hgrant       = grant_q;
    assign hmaster      = master_q;
    assign hsel         = (|grant_q) & htrans[1];
    assign burst_active = (state_q == ST_BURST);

endmodule
